// File: rtl/dut_cmd_engine.sv
// Command engine: 16 x 4-bit register file with write/read/inc/dec and
// whole-file sweep commands (clear/fill) executed one entry per cycle.
module dut_cmd_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cmd,
  input  logic [3:0] adr,
  input  logic [3:0] data,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic [3:0] rsp_adr,
  output logic       rsp_flag,
  output logic       err,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  // Response handshake: rsp_valid is a one-cycle strobe with no ready; the
  // consumer must take rsp_data/rsp_adr/rsp_flag/err in the cycle it is high.
  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_READ  = 4'd2;
  localparam logic [3:0] CMD_INC   = 4'd3;
  localparam logic [3:0] CMD_DEC   = 4'd4;
  localparam logic [3:0] CMD_CLEAR = 4'd5;
  localparam logic [3:0] CMD_FILL  = 4'd6;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t     state;
  logic [3:0] mem [16];
  logic [3:0] ptr;
  logic [3:0] fill_val;

  logic [3:0] cur;
  logic [4:0] sum;
  logic [3:0] diff;
  logic       borrow;

  always_comb begin
    cur    = mem[adr];
    sum    = {1'b0, cur} + {1'b0, data};
    diff   = cur - data;
    borrow = (data > cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
      state     <= IDLE;
      ptr       <= 4'd0;
      fill_val  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 4'd0;
      rsp_adr   <= 4'd0;
      rsp_flag  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_flag  <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          case (cmd)
            CMD_NOP: ;
            CMD_WRITE: begin
              mem[adr]  <= data;
              rsp_valid <= 1'b1;
              rsp_data  <= data;
              rsp_adr   <= adr;
            end
            CMD_READ: begin
              rsp_valid <= 1'b1;
              rsp_data  <= cur;
              rsp_adr   <= adr;
            end
            CMD_INC: begin
              mem[adr]  <= sum[3:0];
              rsp_valid <= 1'b1;
              rsp_data  <= sum[3:0];
              rsp_adr   <= adr;
              rsp_flag  <= sum[4];
            end
            CMD_DEC: begin
              mem[adr]  <= diff;
              rsp_valid <= 1'b1;
              rsp_data  <= diff;
              rsp_adr   <= adr;
              rsp_flag  <= borrow;
            end
            CMD_CLEAR, CMD_FILL: begin
              state    <= SWEEP;
              busy     <= 1'b1;
              ptr      <= 4'd0;
              fill_val <= (cmd == CMD_FILL) ? data : 4'd0;
            end
            default: begin
              err       <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_data  <= 4'd0;
              rsp_adr   <= adr;
            end
          endcase
        end
        SWEEP: begin
          mem[ptr] <= fill_val;
          // Anything arriving mid-sweep is discarded; only real commands count.
          if (cmd != CMD_NOP && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (ptr == 4'd15) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ptr       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_data  <= fill_val;
            rsp_adr   <= 4'd15;
          end else begin
            ptr <= ptr + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_cmd_engine.sv
// Directed bench for dut_cmd_engine: hand-computed expectations for each
// command, sweeps, drops, mid-sweep reset and drop counter saturation.
module tb_dut_cmd_engine;

  logic       clk;
  logic       rst;
  logic [3:0] cmd;
  logic [3:0] adr;
  logic [3:0] data;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic [3:0] rsp_adr;
  logic       rsp_flag;
  logic       err;
  logic       busy;
  logic [7:0] drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_mem [16];

  dut_cmd_engine dut (
    .clk(clk), .rst(rst), .cmd(cmd), .adr(adr), .data(data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_adr(rsp_adr),
    .rsp_flag(rsp_flag), .err(err), .busy(busy), .drop_cnt(drop_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // driver: apply at negedge, sample 1ns after the following posedge
  task automatic issue(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    cmd = c; adr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] d, input logic [3:0] a, input logic f);
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".data"}, rsp_data, d);
    check({tag, ".adr"}, rsp_adr, a);
    check({tag, ".flag"}, rsp_flag, f);
    check({tag, ".err"}, err, 0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      issue(4'd2, i[3:0], 4'd0);
      check($sformatf("%s.rd%0d", tag, i), rsp_data, exp_mem[i]);
    end
  endtask

  // FILL/CLEAR plus 16 follow-up commands; returns observations over the sweep
  task automatic sweep(input logic [3:0] sc, input logic [3:0] sd, input logic [3:0] fc,
                       output int busy_cycles, output int valid_cnt, output int err_cnt,
                       output logic [3:0] last_data);
    busy_cycles = 0; valid_cnt = 0; err_cnt = 0; last_data = 4'd0;
    issue(sc, 4'd0, sd);
    if (busy) busy_cycles++;
    if (rsp_valid) valid_cnt++;
    for (int k = 1; k <= 16; k++) begin
      issue((fc == 4'hF) ? ((k % 2 == 1) ? 4'd1 : 4'd12) : fc, k[3:0], 4'd2);
      if (busy) busy_cycles++;
      if (err) err_cnt++;
      if (rsp_valid) begin
        valid_cnt++;
        last_data = rsp_data;
      end
    end
  endtask

  int bc, vc, ec, vc2;
  logic [3:0] ld;

  initial begin
    rst = 1'b1; cmd = 4'd0; adr = 4'd0; data = 4'd0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
    #1;
    check("rst.valid", rsp_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.drop", drop_cnt, 0);
    check("rst.err", err, 0);
    check("rst.data", rsp_data, 0);

    // first command at the first posedge with rst low
    @(negedge clk);
    rst = 1'b0; cmd = 4'd1; adr = 4'd3; data = 4'd9;
    @(posedge clk);
    #1;
    check_rsp("wr3", 4'd9, 4'd3, 1'b0);
    exp_mem[3] = 4'd9;
    issue(4'd2, 4'd3, 4'd0);
    check_rsp("rd3", 4'd9, 4'd3, 1'b0);
    issue(4'd0, 4'd0, 4'd0);
    check("nop.valid", rsp_valid, 0);

    issue(4'd1, 4'd5, 4'd14);
    check_rsp("wr5", 4'd14, 4'd5, 1'b0);
    issue(4'd3, 4'd5, 4'd3);
    check_rsp("inc5", 4'd1, 4'd5, 1'b1);
    issue(4'd4, 4'd5, 4'd2);
    check_rsp("dec5", 4'd15, 4'd5, 1'b1);
    exp_mem[5] = 4'd15;
    issue(4'd3, 4'd3, 4'd2);
    check_rsp("inc3", 4'd11, 4'd3, 1'b0);
    issue(4'd4, 4'd3, 4'd11);
    check_rsp("dec3", 4'd0, 4'd3, 1'b0);
    issue(4'd3, 4'd3, 4'd11);
    check_rsp("inc3b", 4'd11, 4'd3, 1'b0);
    exp_mem[3] = 4'd11;

    // illegal command
    issue(4'd11, 4'd7, 4'd4);
    check("ill.err", err, 1);
    check("ill.valid", rsp_valid, 1);
    check("ill.data", rsp_data, 0);
    check("ill.adr", rsp_adr, 7);
    issue(4'd0, 4'd0, 4'd0);
    check("ill.err_clr", err, 0);
    check("ill.valid_clr", rsp_valid, 0);
    read_all("ill");

    // FILL 7 with WRITEs on the next 16 edges
    sweep(4'd6, 4'd7, 4'd1, bc, vc, ec, ld);
    check("fill7.busy_cycles", bc, 16);
    check("fill7.valids", vc, 1);
    check("fill7.rsp_data", ld, 7);
    check("fill7.rsp_adr", rsp_adr, 15);
    check("fill7.busy_end", busy, 0);
    check("fill7.drop", drop_cnt, 16);
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd7;
    read_all("fill7");

    // FILL 5 with NOPs: no drops counted
    sweep(4'd6, 4'd5, 4'd0, bc, vc, ec, ld);
    check("fill5.drop", drop_cnt, 16);
    check("fill5.rsp_data", ld, 5);
    issue(4'd2, 4'd0, 4'd0);
    check("fill5.rd0", rsp_data, 5);
    issue(4'd2, 4'd15, 4'd0);
    check("fill5.rd15", rsp_data, 5);

    // CLEAR_ALL aborted by reset before E8
    issue(4'd5, 4'd0, 4'd0);
    check("clr.busy", busy, 1);
    for (int k = 1; k <= 7; k++) issue(4'd1, 4'd2, 4'd3);
    check("clr.drop_pre", drop_cnt, 23);
    @(negedge clk);
    rst = 1'b1; cmd = 4'd0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.valid", rsp_valid, 0);
    check("arst.drop", drop_cnt, 0);
    check("arst.adr", rsp_adr, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vc2 = 0;
    for (int k = 0; k < 20; k++) begin
      issue(4'd0, 4'd0, 4'd0);
      if (rsp_valid) vc2++;
    end
    check("arst.no_completion", vc2, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
    read_all("arst");

    // drop counter saturation; dropped illegal codes never raise err
    for (int s = 0; s < 17; s++) begin
      sweep(4'd6, s[3:0], 4'hF, bc, vc, ec, ld);
      check($sformatf("sat%0d.err", s), ec, 0);
      if (s == 14) check("sat.drop240", drop_cnt, 240);
      if (s == 15) check("sat.drop255", drop_cnt, 255);
    end
    check("sat.drop_hold", drop_cnt, 255);
    issue(4'd2, 4'd9, 4'd0);
    check_rsp("sat.rd9", 4'd0, 4'd9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dut_cmd_engine.md
DUT_CMD_ENGINE -- requirements
Module: dut_cmd_engine

Interface
REQ-001 Parameters: none; data, address and command widths are fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd  input  4  command code, driven by the dut_if master and sampled every posedge.
REQ-005 adr  input  4  register address, 0-15.
REQ-006 data  input  4  operand.
REQ-007 rsp_valid  output  1  one-cycle response strobe.
REQ-008 rsp_data  output  4  response value, meaningful only while rsp_valid=1.
REQ-009 rsp_adr  output  4  address the response refers to.
REQ-010 rsp_flag  output  1  carry on INC, borrow on DEC; 0 for every other command.
REQ-011 err  output  1  one-cycle strobe marking an illegal command.
REQ-012 busy  output  1  high while a sweep command executes.
REQ-013 drop_cnt  output  8  count of non-NOP commands dropped while busy.

Function
REQ-014 Storage is a 16 x 4-bit register file, mem[0..15].
REQ-015 Command codes: 0 NOP, 1 WRITE, 2 READ, 3 INC, 4 DEC, 5 CLEAR_ALL, 6 FILL; codes 7-15 are illegal.
REQ-016 A command is accepted at a posedge only when the registered busy value is 0 before that edge.
REQ-017 Every accepted non-NOP, non-sweep command asserts rsp_valid at the edge it is sampled, so the response is visible in the next cycle (latency 1); rsp_adr equals the sampled adr.
REQ-018 WRITE: mem[adr] takes data; rsp_data = data.
REQ-019 READ: rsp_data = mem[adr]; mem is unchanged.
REQ-020 INC: mem[adr] takes (mem[adr]+data) mod 16; rsp_data = the new value; rsp_flag = the carry-out of the 5-bit sum.
REQ-021 DEC: mem[adr] takes (mem[adr]-data) mod 16; rsp_data = the new value; rsp_flag = 1 if data > old mem[adr].
REQ-022 Illegal code: err=1 and rsp_valid=1 for one cycle; rsp_data=0; mem is unchanged.
REQ-023 NOP: no response and no state change.
REQ-024 Accepting a sweep command sets the state machine to SWEEP.
- CLEAR_ALL writes 0 to every entry; FILL writes the sampled data to every entry.
- The sampled data value is latched at acceptance.
REQ-025 SWEEP sequence:
- ptr starts at 0.
- Edges E1..E16 after acceptance edge E0 write mem[0]..mem[15] in order.
- busy=1 from E0 through E16.
- At E16: rsp_valid=1, rsp_adr=15, rsp_data=fill value (0 for CLEAR_ALL), and the state returns to IDLE.
REQ-026 State machine has two states only: IDLE and SWEEP, with IDLE->SWEEP on an accepted code 5 or 6 and SWEEP->IDLE after the write to ptr=15.
REQ-027 Dropped commands:
- A command sampled while busy=1 (edges E1..E16) is ignored.
- If that command is non-NOP, drop_cnt increments, saturating at 255.
- A dropped illegal code does not raise err.
REQ-028 rsp_valid, err and rsp_flag are low in every cycle without a response.
REQ-029 ptr wraps only by terminating the sweep; a 17th write never occurs.

Reset
REQ-030 rst=1 immediately forces the following, regardless of clk:
- all mem entries = 0;
- state = IDLE and ptr = 0;
- rsp_valid, rsp_data, rsp_adr, rsp_flag, err and busy = 0;
- drop_cnt = 0.
REQ-031 A reset during SWEEP aborts the sweep; no completion response is ever produced for it.
REQ-032 The first command is accepted at the first posedge with rst=0.

Verification
REQ-033 WRITE adr=3 data=9, then READ adr=3 -> response 1: rsp_data=9, rsp_adr=3; response 2: rsp_data=9, rsp_flag=0.
REQ-034 WRITE adr=5 data=14, then INC adr=5 data=3 -> rsp_data=1, rsp_flag=1; then DEC adr=5 data=2 -> rsp_data=15, rsp_flag=1.
REQ-035 FILL data=7, then WRITE on the next 16 edges -> busy high 16 cycles, drop_cnt=16, single rsp_valid with rsp_data=7; READ of any adr then returns 7.
REQ-036 cmd=11 -> err=1 and rsp_valid=1 for one cycle; a full READ sweep afterwards shows mem unchanged.
REQ-037 CLEAR_ALL after filling with 5, rst pulsed at E8 -> all outputs 0, busy=0, no completion rsp_valid, and every READ returns 0.
REQ-038 260 WRITEs issued during repeated sweeps -> drop_cnt saturates at 255.
